// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter and receiver.
package uart_pkg;

    localparam int   UART_CLK_DIV    = 301;  // clk cycles per oversample tick
    localparam int   UART_OVERSAMPLE = 16;   // ticks per bit period
    localparam int   UART_DATA_BITS  = 8;    // data bits per frame
    localparam logic UART_IDLE_LEVEL = 1'b1; // line level between frames

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divider with a one-clk tick on wrap.
// The clear input restarts the divider so that a new frame starts on a clean
// bit boundary.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_DIV = UART_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    // Next divider value: count up, wrap at CLK_DIV-1, restart on clear.
    always_comb begin
        div_d = div_q + 1'b1;
        if (clear || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
    end

    // Divider register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // A clear in the wrap cycle restarts the bit period, so no tick then.
    assign tick = (div_q == DIV_LAST) && !clear;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: accepts a byte over valid/ready and shifts it out
// LSB-first framed by a start bit (0) and a stop bit (1).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int               TICK_W    = $clog2(OVERSAMPLE);
    localparam int               BIT_W     = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    uart_state_e          state_q,    state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic                 serial_q,   serial_d;
    logic                 ready_q,    ready_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;

    logic accept;
    logic tick;

    assign accept = tx_valid && ready_q;

    uart_baud_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .tick  (tick)
    );

    // Next-state logic: frame sequencing, bit shifting and registered-output
    // values derived from the state being entered.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = IDLE;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so the line changes
        // exactly on the clock edge that changes the state.
        serial_d = UART_IDLE_LEVEL;
        if (state_d == START) begin
            serial_d = 1'b0;
        end else if (state_d == DATA) begin
            serial_d = shift_d[0];
        end
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and datapath registers; reset forces the line idle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            serial_q   <= UART_IDLE_LEVEL;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            serial_q   <= serial_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_serial = serial_q;
    assign tx_ready  = ready_q;
    assign tx_busy   = busy_q;
    assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a loopback monitor decodes every frame on
// the line and compares it with a scoreboard of bytes the stimulus expects.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int CLK_DIV = 5;
    localparam int OS      = UART_OVERSAMPLE;
    localparam int DB      = UART_DATA_BITS;
    localparam int BITT    = CLK_DIV * OS;
    localparam int FRAME   = (DB + 2) * BITT;
    localparam int LIMIT   = 3 * FRAME;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic [DB-1:0] tx_data  = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_busy;
    logic          tx_done;

    uart_tx #(
        .CLK_DIV    (CLK_DIV),
        .OVERSAMPLE (OS),
        .DATA_BITS  (DB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_serial (tx_serial),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    logic [DB-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Loopback monitor, sampling on the falling edge.
    int         cyc         = 0;
    int         t0          = 0;
    int         last_t0     = 0;
    int         n           = 0;
    int         frames      = 0;
    int         done_pulses = 0;
    bit         mon_active  = 1'b0;
    bit         have_last   = 1'b0;
    logic [9:0] bits        = '0;
    logic [DB-1:0] e;

    always @(negedge clk) begin
        cyc++;
        if (tx_done === 1'b1) done_pulses++;
        if (reset) begin
            mon_active = 1'b0;
            have_last  = 1'b0;
        end else if (!mon_active) begin
            if (tx_done !== 1'b0) check_eq("stray_done", tx_done, 0);
            if (tx_serial === 1'b0) begin
                mon_active = 1'b1;
                t0         = cyc;
                if (have_last) check_eq("idle_gap", (cyc - last_t0) >= (FRAME + 1), 1);
            end
        end else begin
            n = cyc - t0;
            if ((n < FRAME) && ((n % BITT) == BITT / 2)) begin
                bits[n / BITT] = tx_serial;
                check_eq("busy_mid", tx_busy, 1);
            end
            if ((n < FRAME) && (tx_done !== 1'b0)) check_eq("early_done", tx_done, 0);
            if (n == FRAME) begin
                check_eq("done_at_end", tx_done, 1);
                check_eq("busy_at_end", tx_busy, 0);
                check_eq("ready_at_end", tx_ready, 1);
                check_eq("sb_nonempty", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("frame", bits, {1'b1, e, 1'b0});
                    $display("frame %0d: line %03h expected %03h", frames, bits, {1'b1, e, 1'b0});
                end
                last_t0    = t0;
                have_last  = 1'b1;
                mon_active = 1'b0;
                frames++;
            end
        end
    end

    // Offer a byte (caller sits 1ns after a rising edge); returns 1ns after
    // the accepting edge.
    task automatic send(input logic [DB-1:0] b, input bit hold);
        int w = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && w < LIMIT) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("accept_wait", w < LIMIT, 1);
        if (tx_ready === 1'b1) begin
            exp_q.push_back(b);
            @(posedge clk);
            #1;
            check_eq("start_latency", tx_serial, 0);
            check_eq("ready_drop", tx_ready, 0);
        end
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int w = 0;
        while (frames < target && w < LIMIT) begin
            @(posedge clk);
            #1;
            w++;
        end
        check_eq("frame_wait", frames >= target, 1);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int f0;
    int d0;

    initial begin
        // 1: reset state and a long idle stretch.
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_serial", tx_serial, 1);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_done", tx_done, 0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (100) @(posedge clk);
            #1;
            check_eq("idle_serial", tx_serial, 1);
            check_eq("idle_ready", tx_ready, 1);
            check_eq("idle_busy", tx_busy, 0);
        end
        check_eq("idle_no_done", done_pulses, 0);

        // 2: single frame of 0xA5.
        send(8'hA5, 1'b0);
        wait_frames(1);
        check_eq("a5_done_count", done_pulses, 1);

        // 3: 0x00 then 0xFF with valid held; 0xFF waits for the first frame.
        f0 = frames;
        send(8'h00, 1'b1);
        tx_data = 8'hFF;
        send(8'hFF, 1'b0);
        check_eq("ff_after_done", frames, f0 + 1);
        wait_frames(f0 + 2);

        // 4: a request while the line is busy is ignored.
        f0 = frames;
        send(8'h96, 1'b0);
        repeat (3 * BITT) @(posedge clk);
        #1;
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        check_eq("busy_not_ready", tx_ready, 0);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_frames(f0 + 1);
        repeat (FRAME) @(posedge clk);
        #1;
        check_eq("no_3c_frame", frames, f0 + 1);

        // 5: reset in the middle of frame bit 4 (data bit 3, a 0) of 0x55.
        send(8'h55, 1'b0);
        repeat (4 * BITT + BITT / 2) @(posedge clk);
        #2;
        check_eq("pre_reset_line", tx_serial, 0);
        d0    = done_pulses;
        reset = 1'b1;
        #1;
        check_eq("async_rst_serial", tx_serial, 1);
        check_eq("async_rst_busy", tx_busy, 0);
        check_eq("async_rst_ready", tx_ready, 1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        repeat (FRAME) @(posedge clk);
        #1;
        check_eq("rst_no_done", done_pulses, d0);
        check_eq("rst_line_idle", tx_serial, 1);
        f0 = frames;
        send(8'h55, 1'b0);
        wait_frames(f0 + 1);

        // 6: tx_data changes after acceptance do not disturb the frame.
        f0 = frames;
        send(8'hC3, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        tx_data = 8'h18;
        wait_frames(f0 + 1);
        check_eq("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
